disp_share_arbiter: RTL and testbench

- Shares the single 8-digit seven-segment display path (the SEG_OUT driver) between up to N_REQ data sources, e.g. the stopwatch, CPU debug registers and switch echo.
- Grants ownership round-robin with a minimum dwell time, and supports a user "next" button and a lock mode.
- Outputs the owner's 32-bit word to the display driver each cycle, plus grant and owner-ID status.

---
 rtl/disp_arb_pkg.sv | 16 +
 rtl/disp_share_arbiter_rr_next_picker.sv | 47 ++++
 rtl/disp_share_arbiter.sv | 139 +++++++++++++
 tb/tb_disp_share_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/disp_arb_pkg.sv
// Shared types and helpers for the seven-segment display share arbiter.
package disp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DWELL_CYC_DEF = 10000000;
  localparam int MAX_REQ       = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
    onehot = 8'd1 << id;
  endfunction

endpackage

// File: rtl/disp_share_arbiter_rr_next_picker.sv
// Combinational round-robin finder: first requester after last_id, wrapping,
// with last_id itself as the final candidate and an optional excluded index.
module rr_next_picker
  import disp_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  input  logic             exclude_en,
  input  logic [ID_W-1:0]  exclude_id,
  output logic             found,
  output logic [ID_W-1:0]  pick_id
);

  logic            found_s;
  logic [ID_W-1:0] pick_s;
  logic [ID_W-1:0] idx_s;
  logic            hit_s;
  int              idx_full_s;

  // Scan farthest candidate first so the nearest hit overwrites it.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = '0;
    idx_s      = '0;
    hit_s      = 1'b0;
    idx_full_s = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_full_s = (int'(last_id) + k) % N_REQ;
      idx_s      = idx_full_s[ID_W-1:0];
      hit_s      = req[idx_s] && !(exclude_en && (idx_s == exclude_id));
      if (hit_s) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
        pick_s  = pick_s;
      end
    end
  end

  assign found   = found_s;
  assign pick_id = pick_s;

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the shared seven-segment display path with minimum
// dwell, a "next" button override and a lock that keeps the owner past dwell.
module disp_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DWELL_CYC = DWELL_CYC_DEF,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] data_in,
  input  logic                next_btn,
  input  logic                lock,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_W-1:0]     cur_id,
  output logic                disp_valid,
  output logic [31:0]         disp_data
);

  localparam int          DW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC - 1);

  arb_state_e         state_r, state_s;
  logic [N_REQ-1:0]   grant_s;
  logic [ID_W-1:0]    cur_id_s;
  logic [ID_W-1:0]    last_id_r;
  logic [DW-1:0]      dwell_r, dwell_s;
  logic               take_s;
  logic               excl_en_s;
  logic               expired_s;
  logic               found_s;
  logic [ID_W-1:0]    pick_s;
  logic [MAX_REQ-1:0] oh_s;
  logic [31:0]        words_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words_s[g] = data_in[32*g +: 32];
  end

  rr_next_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req        (req),
    .last_id    (last_id_r),
    .exclude_en (excl_en_s),
    .exclude_id (cur_id),
    .found      (found_s),
    .pick_id    (pick_s)
  );

  // Next-state decode; take_s marks a hand-over to pick_s on the next edge.
  always_comb begin
    excl_en_s = (state_r == OWN) && req[cur_id];
    expired_s = (dwell_r == DWELL_MAX);
    oh_s      = onehot(3'(pick_s));
    state_s   = state_r;
    grant_s   = grant;
    cur_id_s  = cur_id;
    dwell_s   = dwell_r;
    take_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      OWN: begin
        if (!req[cur_id]) begin
          if (found_s) begin
            take_s = 1'b1;
          end else begin
            state_s  = IDLE;
            grant_s  = '0;
            cur_id_s = '0;
            dwell_s  = '0;
          end
        end else if (next_btn || (expired_s && !lock)) begin
          if (found_s) begin
            take_s = 1'b1;
          end else begin
            dwell_s = '0;
          end
        end else if (expired_s) begin
          dwell_s = DWELL_MAX;
        end else begin
          dwell_s = dwell_r + 1'b1;
        end
      end
      default: begin
        state_s  = IDLE;
        grant_s  = '0;
        cur_id_s = '0;
        dwell_s  = '0;
      end
    endcase
  end

  // Ownership registers; a hand-over restarts dwell and moves the search origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      grant     <= '0;
      cur_id    <= '0;
      last_id_r <= ID_W'(N_REQ - 1);
      dwell_r   <= '0;
    end else if (take_s) begin
      state_r   <= OWN;
      grant     <= oh_s[N_REQ-1:0];
      cur_id    <= pick_s;
      last_id_r <= pick_s;
      dwell_r   <= '0;
    end else begin
      state_r   <= state_s;
      grant     <= grant_s;
      cur_id    <= cur_id_s;
      dwell_r   <= dwell_s;
    end
  end

  // Display word follows the registered owner, one edge behind the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid <= 1'b0;
      disp_data  <= 32'd0;
    end else if (state_r == OWN) begin
      disp_valid <= 1'b1;
      disp_data  <= words_s[cur_id];
    end else begin
      disp_valid <= 1'b0;
      disp_data  <= 32'd0;
    end
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter with a short dwell of 8 cycles.
module tb_disp_share_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [127:0] data_in = {32'h33333333, 32'h12345678, 32'h11111111, 32'hAAAA0000};
  logic         next_btn = 1'b0;
  logic         lock = 1'b0;
  logic [3:0]   grant;
  logic [1:0]   cur_id;
  logic         disp_valid;
  logic [31:0]  disp_data;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  disp_share_arbiter #(
    .N_REQ     (4),
    .DWELL_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .next_btn   (next_btn),
    .lock       (lock),
    .grant      (grant),
    .cur_id     (cur_id),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    req      = 4'b0000;
    next_btn = 1'b0;
    lock     = 1'b0;
    cyc(2);
    rst      = 1'b0;
  endtask

  initial begin
    // Reset values and first grant latency
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_id", 32'(cur_id), 32'h0);
    chk("rst_valid", 32'(disp_valid), 32'h0);
    chk("rst_data", disp_data, 32'h0);
    req = 4'b0100;
    cyc(1);
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_id", 32'(cur_id), 32'h2);
    chk("t1_valid_early", 32'(disp_valid), 32'h0);
    cyc(1);
    chk("t1_data", disp_data, 32'h12345678);
    chk("t1_valid", 32'(disp_valid), 32'h1);
    data_in[64 +: 32] = 32'hCAFEF00D;
    cyc(1);
    chk("t1_data_follow", disp_data, 32'hCAFEF00D);

    // Dwell-based alternation between sources 0 and 2
    do_reset();
    req = 4'b0101;
    for (int c = 1; c <= 24; c++) begin
      cyc(1);
      chk("rr_alt", 32'(grant), (((c - 1) / 8) % 2 == 0) ? 32'h1 : 32'h4);
    end

    // next_btn forces an advance and restarts dwell
    do_reset();
    req = 4'b1100;
    cyc(1);
    chk("nb_first", 32'(grant), 32'h4);
    cyc(2);
    chk("nb_before", 32'(grant), 32'h4);
    next_btn = 1'b1;
    cyc(1);
    next_btn = 1'b0;
    chk("nb_grant", 32'(grant), 32'h8);
    chk("nb_id", 32'(cur_id), 32'h3);
    for (int c = 5; c <= 11; c++) begin
      cyc(1);
      chk("nb_dwell", 32'(grant), 32'h8);
    end
    cyc(1);
    chk("nb_expire", 32'(grant), 32'h4);
    req = 4'b1110;
    cyc(7);
    chk("co_before", 32'(grant), 32'h4);
    next_btn = 1'b1;
    cyc(1);
    next_btn = 1'b0;
    chk("co_single", 32'(grant), 32'h8);
    cyc(1);
    chk("co_hold", 32'(grant), 32'h8);

    // Lock holds the owner past dwell; owner drop paths
    do_reset();
    req  = 4'b0011;
    lock = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      cyc(1);
      chk("lock_hold", 32'(grant), 32'h1);
    end
    lock = 1'b0;
    cyc(1);
    chk("unlock_grant", 32'(grant), 32'h2);
    chk("unlock_id", 32'(cur_id), 32'h1);
    req = 4'b0001;
    cyc(1);
    chk("drop_switch", 32'(grant), 32'h1);
    req = 4'b0000;
    cyc(1);
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_id", 32'(cur_id), 32'h0);
    chk("idle_valid_lag", 32'(disp_valid), 32'h1);
    chk("idle_data_lag", disp_data, 32'hAAAA0000);
    cyc(1);
    chk("idle_valid", 32'(disp_valid), 32'h0);
    chk("idle_data", disp_data, 32'h0);

    // Asynchronous reset mid-ownership, then restart from index 0
    do_reset();
    req = 4'b1000;
    cyc(3);
    chk("o3_grant", 32'(grant), 32'h8);
    chk("o3_data", disp_data, 32'h33333333);
    req = 4'b1010;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_id", 32'(cur_id), 32'h0);
    chk("arst_valid", 32'(disp_valid), 32'h0);
    chk("arst_data", disp_data, 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_id", 32'(cur_id), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
